hazard_fwd_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage ARM datapath (IF/ID/EX/MEM/WB).

---
 rtl/hazard_fwd_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage ARM pipeline: operand forwarding selects,
// load-use stalls, taken-branch IF/ID flush, global memory freeze and saturating stall/flush counters.
module hazard_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic             ID_B,
  input  logic             Cond,
  input  logic             EX_RF,
  input  logic             EX_load_instr,
  input  logic [3:0]       EX_Rd,
  input  logic [3:0]       MEM_Rd,
  input  logic [3:0]       WB_Rd,
  input  logic             MEM_RF,
  input  logic             WB_RF,
  input  logic             mem_busy,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       fwd_C,
  output logic             PC_load,
  output logic             IF_ID_load,
  output logic             NOP_sel,
  output logic             IF_ID_clear,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;
  logic   load_use, br_taken, stall_inc;

  // R15 is the PC and is never forwarded; an ALU result in EX beats older results.
  function automatic logic [1:0] fwd_sel(input logic       use_src,
                                         input logic [3:0] src,
                                         input logic       ex_rf,
                                         input logic       ex_ld,
                                         input logic [3:0] ex_rd,
                                         input logic       mem_rf,
                                         input logic [3:0] mem_rd,
                                         input logic       wb_rf,
                                         input logic [3:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && src != 4'hF) begin
      if (ex_rf && !ex_ld && ex_rd == src) sel = 2'b01;
      else if (mem_rf && mem_rd == src)    sel = 2'b10;
      else if (wb_rf && wb_rd == src)      sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_A = 2'b00;
    fwd_B = 2'b00;
    fwd_C = 2'b00;
    if (!reset) begin
      fwd_A = fwd_sel(ID_use_Rn, ID_Rn, EX_RF, EX_load_instr, EX_Rd, MEM_RF, MEM_Rd, WB_RF, WB_Rd);
      fwd_B = fwd_sel(ID_use_Rm, ID_Rm, EX_RF, EX_load_instr, EX_Rd, MEM_RF, MEM_Rd, WB_RF, WB_Rd);
      fwd_C = fwd_sel(ID_use_Rd, ID_Rd, EX_RF, EX_load_instr, EX_Rd, MEM_RF, MEM_Rd, WB_RF, WB_Rd);
    end
  end

  assign load_use = EX_RF & EX_load_instr &
                    ((ID_use_Rn & (ID_Rn == EX_Rd)) |
                     (ID_use_Rm & (ID_Rm == EX_Rd)) |
                     (ID_use_Rd & (ID_Rd == EX_Rd)));
  assign br_taken = ID_B & Cond;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    PC_load     = 1'b1;
    IF_ID_load  = 1'b1;
    NOP_sel     = 1'b0;
    IF_ID_clear = 1'b0;
    case (state)
      RUN: begin
        // A stall wins over a branch; the branch stays in ID and flushes once released.
        if (load_use) begin
          state_next = STALL;
          PC_load    = 1'b0;
          IF_ID_load = 1'b0;
          NOP_sel    = 1'b1;
        end else if (br_taken) begin
          state_next  = FLUSH;
          IF_ID_clear = 1'b1;
        end
      end
      STALL, FLUSH: state_next = RUN;
      default:      state_next = RUN;
    endcase
    if (mem_busy) begin
      state_next  = state;
      PC_load     = 1'b0;
      IF_ID_load  = 1'b0;
      NOP_sel     = 1'b0;
      IF_ID_clear = 1'b0;
    end
    if (reset) begin
      state_next  = RUN;
      PC_load     = 1'b0;
      IF_ID_load  = 1'b0;
      NOP_sel     = 1'b1;
      IF_ID_clear = 1'b0;
    end
  end

  assign stall_inc = (state == RUN) & load_use & ~mem_busy;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_ID_clear && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: a behavioural model pushes the expected outputs of each cycle
// into a queue; they are popped and compared against a 16-bit and a 4-bit counter instance.
module tb_hazard_fwd_ctrl;

  localparam int EXP_W = 52;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd;
  logic       ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_B, Cond;
  logic       EX_RF, EX_load_instr, MEM_RF, WB_RF, mem_busy;

  logic [1:0]  fwd_A, fwd_B, fwd_C, fsm_state;
  logic        PC_load, IF_ID_load, NOP_sel, IF_ID_clear;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_fwd_A, s_fwd_B, s_fwd_C, s_fsm_state;
  logic        s_PC_load, s_IF_ID_load, s_NOP_sel, s_IF_ID_clear;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EXP_W-1:0] exp_q[$];

  // model state
  logic [1:0]  m_state;
  logic [15:0] m_stall, m_flush;
  logic [3:0]  m_stall4, m_flush4;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .ID_B(ID_B), .Cond(Cond), .EX_RF(EX_RF), .EX_load_instr(EX_load_instr),
    .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_RF(MEM_RF), .WB_RF(WB_RF),
    .mem_busy(mem_busy),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_C(fwd_C),
    .PC_load(PC_load), .IF_ID_load(IF_ID_load), .NOP_sel(NOP_sel), .IF_ID_clear(IF_ID_clear),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(fsm_state)
  );

  hazard_fwd_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .ID_B(ID_B), .Cond(Cond), .EX_RF(EX_RF), .EX_load_instr(EX_load_instr),
    .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_RF(MEM_RF), .WB_RF(WB_RF),
    .mem_busy(mem_busy),
    .fwd_A(s_fwd_A), .fwd_B(s_fwd_B), .fwd_C(s_fwd_C),
    .PC_load(s_PC_load), .IF_ID_load(s_IF_ID_load), .NOP_sel(s_NOP_sel),
    .IF_ID_clear(s_IF_ID_clear),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .fsm_state(s_fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic u, input logic [3:0] r);
    if (reset || !u || r == 4'hF)              return 2'b00;
    if (EX_RF && !EX_load_instr && EX_Rd == r) return 2'b01;
    if (MEM_RF && MEM_Rd == r)                 return 2'b10;
    if (WB_RF && WB_Rd == r)                   return 2'b11;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rd = 4'd0;
    ID_use_Rn = 1'b0; ID_use_Rm = 1'b0; ID_use_Rd = 1'b0; ID_B = 1'b0; Cond = 1'b0;
    EX_RF = 1'b0; EX_load_instr = 1'b0; EX_Rd = 4'd0; MEM_Rd = 4'd0; WB_Rd = 4'd0;
    MEM_RF = 1'b0; WB_RF = 1'b0; mem_busy = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven; ends after the next falling edge.
  task automatic cycle();
    logic             lu, br;
    logic [3:0]       ctrl;
    logic [EXP_W-1:0] e;
    lu = EX_RF && EX_load_instr &&
         ((ID_use_Rn && ID_Rn == EX_Rd) || (ID_use_Rm && ID_Rm == EX_Rd) ||
          (ID_use_Rd && ID_Rd == EX_Rd));
    br = ID_B && Cond;
    if (reset)                      ctrl = 4'b0010;
    else if (mem_busy)              ctrl = 4'b0000;
    else if (m_state == 2'd0 && lu) ctrl = 4'b0010;
    else if (m_state == 2'd0 && br) ctrl = 4'b1101;
    else                            ctrl = 4'b1100;
    exp_q.push_back({m_fwd(ID_use_Rn, ID_Rn), m_fwd(ID_use_Rm, ID_Rm), m_fwd(ID_use_Rd, ID_Rd),
                     ctrl, m_state, m_stall, m_flush, m_stall4, m_flush4});
    #1;
    e = exp_q.pop_front();
    check("fwd",       {26'd0, fwd_A, fwd_B, fwd_C}, {26'd0, e[51:46]});
    check("ctrl",      {28'd0, PC_load, IF_ID_load, NOP_sel, IF_ID_clear}, {28'd0, e[45:42]});
    check("state",     {30'd0, fsm_state}, {30'd0, e[41:40]});
    check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e[39:24]});
    check("flush_cnt", {16'd0, flush_cnt}, {16'd0, e[23:8]});
    check("sat_fwd",   {26'd0, s_fwd_A, s_fwd_B, s_fwd_C}, {26'd0, e[51:46]});
    check("sat_ctrl",  {28'd0, s_PC_load, s_IF_ID_load, s_NOP_sel, s_IF_ID_clear},
          {28'd0, e[45:42]});
    check("sat_state", {30'd0, s_fsm_state}, {30'd0, e[41:40]});
    check("sat_stall", {28'd0, s_stall_cnt}, {28'd0, e[7:4]});
    check("sat_flush", {28'd0, s_flush_cnt}, {28'd0, e[3:0]});
    @(posedge clk);
    if (reset) begin
      m_state = 2'd0; m_stall = '0; m_flush = '0; m_stall4 = '0; m_flush4 = '0;
    end else if (!mem_busy) begin
      if (m_state == 2'd0 && lu) begin
        if (m_stall != 16'hFFFF) m_stall++;
        if (m_stall4 != 4'hF)    m_stall4++;
      end
      if (ctrl[0]) begin
        if (m_flush != 16'hFFFF) m_flush++;
        if (m_flush4 != 4'hF)    m_flush4++;
      end
      if (m_state == 2'd0) m_state = lu ? 2'd1 : (br ? 2'd2 : 2'd0);
      else                 m_state = 2'd0;
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_state = 2'd0; m_stall = '0; m_flush = '0; m_stall4 = '0; m_flush4 = '0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    cycle();                                        // outputs forced while in reset
    clear_inputs(); cycle();

    // ALU result in EX forwards even when MEM/WB also hold r1
    EX_RF = 1; EX_Rd = 4'd1; ID_Rn = 4'd1; ID_use_Rn = 1; cycle();
    MEM_RF = 1; MEM_Rd = 4'd1; WB_RF = 1; WB_Rd = 4'd1; cycle();
    EX_RF = 0; cycle();                             // MEM now wins
    MEM_RF = 0; cycle();                            // WB

    // load-use on Rm, then forwarded from MEM during the bubble
    clear_inputs();
    EX_RF = 1; EX_load_instr = 1; EX_Rd = 4'd2; ID_Rm = 4'd2; ID_use_Rm = 1; cycle();
    EX_RF = 0; EX_load_instr = 0; MEM_RF = 1; MEM_Rd = 4'd2; cycle();
    clear_inputs(); cycle();

    // taken branch flushes once; untaken does nothing
    ID_B = 1; Cond = 1; cycle();
    clear_inputs(); cycle();
    ID_B = 1; Cond = 0; cycle();

    // load-use and branch together: stall first, flush after release
    clear_inputs();
    ID_B = 1; Cond = 1; EX_RF = 1; EX_load_instr = 1; EX_Rd = 4'd3; ID_Rn = 4'd3; ID_use_Rn = 1;
    cycle();
    EX_RF = 0; EX_load_instr = 0; cycle();
    cycle();
    clear_inputs(); cycle();

    // memory freeze while in STALL
    EX_RF = 1; EX_load_instr = 1; EX_Rd = 4'd4; ID_Rd = 4'd4; ID_use_Rd = 1; cycle();
    EX_RF = 0; EX_load_instr = 0; mem_busy = 1;
    repeat (3) cycle();
    mem_busy = 0; cycle();
    clear_inputs(); cycle();

    // R15 is never forwarded
    EX_RF = 1; EX_Rd = 4'hF; ID_Rn = 4'hF; ID_use_Rn = 1; cycle();

    // reset mid-FLUSH
    clear_inputs(); ID_B = 1; Cond = 1; cycle();
    reset = 1; cycle();
    clear_inputs(); cycle();

    // drive both small counters into saturation
    repeat (20) begin
      ID_B = 1; Cond = 1; cycle();
      clear_inputs(); cycle();
    end
    repeat (20) begin
      EX_RF = 1; EX_load_instr = 1; EX_Rd = 4'd5; ID_Rm = 4'd5; ID_use_Rm = 1; cycle();
      clear_inputs(); cycle();
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      ID_Rn = rnd_reg(); ID_Rm = rnd_reg(); ID_Rd = rnd_reg();
      ID_use_Rn = 1'($urandom_range(0, 1)); ID_use_Rm = 1'($urandom_range(0, 1));
      ID_use_Rd = 1'($urandom_range(0, 1));
      ID_B = ($urandom_range(0, 3) == 0); Cond = 1'($urandom_range(0, 1));
      EX_RF = 1'($urandom_range(0, 1)); EX_load_instr = 1'($urandom_range(0, 1));
      EX_Rd = rnd_reg(); MEM_Rd = rnd_reg(); WB_Rd = rnd_reg();
      MEM_RF = 1'($urandom_range(0, 1)); WB_RF = 1'($urandom_range(0, 1));
      mem_busy = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
